// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-index constants and the
// operand-fetch state encoding.
package cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

  // IDLE: empty, READ: BRAM read in flight, VALID: operands presented.
  typedef enum logic [1:0] {
    IDLE,
    READ,
    VALID
  } of_state_t;

endpackage

// File: rtl/operand_bypass.sv
// Per-operand source select: zero for x0/unused, then writeback at the
// resolving edge, then writeback captured at the accept edge, else BRAM data.
module operand_bypass
  import cpu_pkg::*;
(
  input  logic                 uses,
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [XLEN-1:0]      rf_data,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 cap_hit,
  input  logic [XLEN-1:0]      cap_data,
  output logic [XLEN-1:0]      op
);

  // Priority select; rs != 0 in the later arms so wb_reg == 0 can never match.
  always_comb begin
    op = rf_data;
    if (!uses || (rs == REG_ZERO)) begin
      op = '0;
    end else if (wb_en && (wb_reg == rs)) begin
      op = wb_data;
    end else if (cap_hit) begin
      // BRAM returned the pre-write value on the accept edge.
      op = cap_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch: issues BRAM register-file reads on accept,
// waits the one-cycle read latency, then presents registered operands with
// writeback bypass covering the read-during-write gap.
module operand_fetch
  import cpu_pkg::*;
#(
  parameter int unsigned CTRL_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [REG_IDX_W-1:0] in_rs1,
  input  logic [REG_IDX_W-1:0] in_rs2,
  input  logic                 in_uses_rs1,
  input  logic                 in_uses_rs2,
  input  logic [REG_IDX_W-1:0] in_rd,
  input  logic [XLEN-1:0]      in_imm,
  input  logic [CTRL_W-1:0]    in_ctrl,
  output logic                 rf_rd_1_en,
  output logic                 rf_rd_2_en,
  output logic [REG_IDX_W-1:0] rf_read_reg_1,
  output logic [REG_IDX_W-1:0] rf_read_reg_2,
  input  logic [XLEN-1:0]      rf_data_out_1,
  input  logic [XLEN-1:0]      rf_data_out_2,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_reg,
  input  logic [XLEN-1:0]      wb_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_op1,
  output logic [XLEN-1:0]      out_op2,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [XLEN-1:0]      out_imm,
  output logic [CTRL_W-1:0]    out_ctrl
);

  of_state_t state_q, state_d;

  logic                 accept;
  logic                 cap_hit1_d, cap_hit2_d;
  logic                 hold_hit1, hold_hit2;
  logic [XLEN-1:0]      byp_op1, byp_op2;

  // Instruction fields captured at accept, kept through VALID for hold updates.
  logic                 pend_uses1_q, pend_uses2_q;
  logic [REG_IDX_W-1:0] pend_rs1_q, pend_rs2_q;
  logic [REG_IDX_W-1:0] pend_rd_q;
  logic [XLEN-1:0]      pend_imm_q;
  logic [CTRL_W-1:0]    pend_ctrl_q;
  logic                 cap_hit1_q, cap_hit2_q;
  logic [XLEN-1:0]      cap_data1_q, cap_data2_q;

  logic [XLEN-1:0]      out_op1_q, out_op2_q, out_imm_q;
  logic [REG_IDX_W-1:0] out_rd_q;
  logic [CTRL_W-1:0]    out_ctrl_q;

  // Handshake, read-port drive, bypass hit detection and next state.
  always_comb begin
    in_ready      = !flush && ((state_q == IDLE) || ((state_q == VALID) && out_ready));
    accept        = in_valid && in_ready;
    // Reads only in accept cycles so BRAM output holds until resolved.
    rf_rd_1_en    = accept && in_uses_rs1 && (in_rs1 != REG_ZERO);
    rf_rd_2_en    = accept && in_uses_rs2 && (in_rs2 != REG_ZERO);
    rf_read_reg_1 = in_rs1;
    rf_read_reg_2 = in_rs2;

    cap_hit1_d = wb_en && (wb_reg != REG_ZERO) && in_uses_rs1 && (wb_reg == in_rs1);
    cap_hit2_d = wb_en && (wb_reg != REG_ZERO) && in_uses_rs2 && (wb_reg == in_rs2);

    hold_hit1 = (state_q == VALID) && !out_ready && !flush && wb_en &&
                (wb_reg != REG_ZERO) && pend_uses1_q && (wb_reg == pend_rs1_q);
    hold_hit2 = (state_q == VALID) && !out_ready && !flush && wb_en &&
                (wb_reg != REG_ZERO) && pend_uses2_q && (wb_reg == pend_rs2_q);

    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (accept) state_d = READ;
        READ:    state_d = VALID;
        VALID:   if (out_ready) state_d = accept ? READ : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  operand_bypass u_bypass_1 (
    .uses     (pend_uses1_q),
    .rs       (pend_rs1_q),
    .rf_data  (rf_data_out_1),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .cap_hit  (cap_hit1_q),
    .cap_data (cap_data1_q),
    .op       (byp_op1)
  );

  operand_bypass u_bypass_2 (
    .uses     (pend_uses2_q),
    .rs       (pend_rs2_q),
    .rf_data  (rf_data_out_2),
    .wb_en    (wb_en),
    .wb_reg   (wb_reg),
    .wb_data  (wb_data),
    .cap_hit  (cap_hit2_q),
    .cap_data (cap_data2_q),
    .op       (byp_op2)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Capture instruction fields and accept-edge writeback hits.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_uses1_q <= 1'b0;
      pend_uses2_q <= 1'b0;
      pend_rs1_q   <= '0;
      pend_rs2_q   <= '0;
      pend_rd_q    <= '0;
      pend_imm_q   <= '0;
      pend_ctrl_q  <= '0;
      cap_hit1_q   <= 1'b0;
      cap_hit2_q   <= 1'b0;
      cap_data1_q  <= '0;
      cap_data2_q  <= '0;
    end else if (accept) begin
      pend_uses1_q <= in_uses_rs1;
      pend_uses2_q <= in_uses_rs2;
      pend_rs1_q   <= in_rs1;
      pend_rs2_q   <= in_rs2;
      pend_rd_q    <= in_rd;
      pend_imm_q   <= in_imm;
      pend_ctrl_q  <= in_ctrl;
      cap_hit1_q   <= cap_hit1_d;
      cap_hit2_q   <= cap_hit2_d;
      cap_data1_q  <= wb_data;
      cap_data2_q  <= wb_data;
    end
  end

  // Output registers: load resolved operands leaving READ, patch during hold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_op1_q  <= '0;
      out_op2_q  <= '0;
      out_rd_q   <= '0;
      out_imm_q  <= '0;
      out_ctrl_q <= '0;
    end else if ((state_q == READ) && !flush) begin
      out_op1_q  <= byp_op1;
      out_op2_q  <= byp_op2;
      out_rd_q   <= pend_rd_q;
      out_imm_q  <= pend_imm_q;
      out_ctrl_q <= pend_ctrl_q;
    end else begin
      if (hold_hit1) out_op1_q <= wb_data;
      if (hold_hit2) out_op2_q <= wb_data;
    end
  end

  assign out_valid = (state_q == VALID);
  assign out_op1   = out_op1_q;
  assign out_op2   = out_op2_q;
  assign out_rd    = out_rd_q;
  assign out_imm   = out_imm_q;
  assign out_ctrl  = out_ctrl_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a BRAM register-file model with one-cycle read
// latency and read-old-on-write, directed stimulus, and a scoreboard queue
// drained by a monitor whenever execute consumes an output.
module tb_operand_fetch;

  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_rs1, in_rs2, in_rd;
  logic          in_uses_rs1, in_uses_rs2;
  logic [31:0]   in_imm;
  logic [CW-1:0] in_ctrl;
  logic          rf_rd_1_en, rf_rd_2_en;
  logic [4:0]    rf_read_reg_1, rf_read_reg_2;
  logic [31:0]   rf_data_out_1, rf_data_out_2;
  logic          wb_en;
  logic [4:0]    wb_reg;
  logic [31:0]   wb_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_op1, out_op2, out_imm;
  logic [4:0]    out_rd;
  logic [CW-1:0] out_ctrl;

  typedef struct packed {
    logic [31:0]   op1;
    logic [31:0]   op2;
    logic [4:0]    rd;
    logic [31:0]   imm;
    logic [CW-1:0] ctrl;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_act, mon_exp;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [32];

  always #5 clk = ~clk;

  operand_fetch #(.CTRL_W(CW)) dut (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rs1        (in_rs1),
    .in_rs2        (in_rs2),
    .in_uses_rs1   (in_uses_rs1),
    .in_uses_rs2   (in_uses_rs2),
    .in_rd         (in_rd),
    .in_imm        (in_imm),
    .in_ctrl       (in_ctrl),
    .rf_rd_1_en    (rf_rd_1_en),
    .rf_rd_2_en    (rf_rd_2_en),
    .rf_read_reg_1 (rf_read_reg_1),
    .rf_read_reg_2 (rf_read_reg_2),
    .rf_data_out_1 (rf_data_out_1),
    .rf_data_out_2 (rf_data_out_2),
    .wb_en         (wb_en),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_op1       (out_op1),
    .out_op2       (out_op2),
    .out_rd        (out_rd),
    .out_imm       (out_imm),
    .out_ctrl      (out_ctrl)
  );

  // Register file: reads return the pre-write value on a same-edge write.
  always @(posedge clk) begin
    if (rf_rd_1_en) rf_data_out_1 <= mem[rf_read_reg_1];
    if (rf_rd_2_en) rf_data_out_2 <= mem[rf_read_reg_2];
    if (wb_en && (wb_reg != 5'd0)) mem[wb_reg] <= wb_data;
  end

  // Monitor: every consumed output must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      mon_act = '{op1: out_op1, op2: out_op2, rd: out_rd, imm: out_imm, ctrl: out_ctrl};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL output: got %h expected %h", mon_act, mon_exp);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                       input logic u2, input logic [4:0] rd, input logic [31:0] imm,
                       input logic [CW-1:0] ctrl);
    in_valid    = 1'b1;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_uses_rs1 = u1;
    in_uses_rs2 = u2;
    in_rd       = rd;
    in_imm      = imm;
    in_ctrl     = ctrl;
  endtask

  task automatic wb(input logic en, input logic [4:0] r, input logic [31:0] d);
    wb_en   = en;
    wb_reg  = r;
    wb_data = d;
  endtask

  task automatic expect_out(input logic [31:0] op1, input logic [31:0] op2,
                            input logic [4:0] rd, input logic [31:0] imm,
                            input logic [CW-1:0] ctrl);
    exp_q.push_back('{op1: op1, op2: op2, rd: rd, imm: imm, ctrl: ctrl});
  endtask

  initial begin
    reset = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0;
    in_imm = '0; in_ctrl = '0;
    out_ready = 1'b1;
    wb(1'b0, 5'd0, 32'h0);
    #2;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_op1", out_op1, 0);
    chk("reset_op2", out_op2, 0);
    chk("reset_rd", out_rd, 0);
    chk("reset_imm", out_imm, 0);
    chk("reset_ctrl", out_ctrl, 0);

    // Preload x5/x6 through the writeback port while the stage is in reset.
    step();
    wb(1'b1, 5'd5, 32'h11);
    step();
    wb(1'b1, 5'd6, 32'h22);
    step();
    wb(1'b0, 5'd0, 32'h0);
    reset = 1'b1;
    #1;
    chk("in_ready_after_reset", in_ready, 1);

    // Basic read with latency check.
    issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd7, 32'h1234, 16'hA5A5);
    #1;
    chk("basic_rd1_en", rf_rd_1_en, 1);
    chk("basic_rd2_en", rf_rd_2_en, 1);
    chk("basic_rd_addr1", rf_read_reg_1, 5);
    chk("basic_rd_addr2", rf_read_reg_2, 6);
    expect_out(32'h11, 32'h22, 5'd7, 32'h1234, 16'hA5A5);
    step();
    in_valid = 1'b0;
    chk("read_out_valid", out_valid, 0);
    chk("read_in_ready", in_ready, 0);
    step();
    chk("valid_out_valid", out_valid, 1);
    step();
    chk("idle_out_valid", out_valid, 0);

    // Accept-edge bypass: x5 written on the accept edge, BRAM returns old 0x11.
    issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd1, 32'h0, 16'h0001);
    wb(1'b1, 5'd5, 32'hAA);
    expect_out(32'hAA, 32'h22, 5'd1, 32'h0, 16'h0001);
    step();
    in_valid = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    step();
    step();

    // Writes at both edges to x6: the resolving-edge value wins.
    issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd2, 32'hFFFF_0000, 16'h0002);
    wb(1'b1, 5'd6, 32'h99);
    expect_out(32'hAA, 32'hBB, 5'd2, 32'hFFFF_0000, 16'h0002);
    step();
    in_valid = 1'b0;
    wb(1'b1, 5'd6, 32'hBB);
    step();
    wb(1'b0, 5'd0, 32'h0);
    step();

    // x0 source and unused rs2, with writeback targeting x0.
    issue(5'd0, 5'd6, 1'b1, 1'b0, 5'd3, 32'h5, 16'h0003);
    wb(1'b1, 5'd0, 32'hFF);
    #1;
    chk("x0_rd1_en", rf_rd_1_en, 0);
    chk("unused_rd2_en", rf_rd_2_en, 0);
    expect_out(32'h0, 32'h0, 5'd3, 32'h5, 16'h0003);
    step();
    in_valid = 1'b0;
    step();
    wb(1'b0, 5'd0, 32'h0);
    step();

    // Backpressure for three cycles with a hold update on rs1.
    out_ready = 1'b0;
    issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd3, 32'h0000_0BAD, 16'h00C3);
    expect_out(32'hCC, 32'hBB, 5'd3, 32'h0000_0BAD, 16'h00C3);
    step();
    in_valid = 1'b0;
    step();
    issue(5'd6, 5'd5, 1'b1, 1'b1, 5'd4, 32'h4444, 16'h0044);
    #1;
    chk("hold_in_ready", in_ready, 0);
    chk("hold_rd1_en", rf_rd_1_en, 0);
    chk("hold_out_valid", out_valid, 1);
    chk("hold_op1_pre", out_op1, 32'hAA);
    chk("hold_op2_pre", out_op2, 32'hBB);
    wb(1'b1, 5'd5, 32'hCC);
    step();
    wb(1'b0, 5'd0, 32'h0);
    chk("hold_op1_updated", out_op1, 32'hCC);
    chk("hold_op2_stable", out_op2, 32'hBB);
    chk("hold_rd_stable", out_rd, 3);
    step();
    chk("hold_op1_stable", out_op1, 32'hCC);
    chk("hold_valid_stable", out_valid, 1);
    out_ready = 1'b1;
    #1;
    chk("consume_in_ready", in_ready, 1);
    chk("consume_rd1_en", rf_rd_1_en, 1);
    expect_out(32'hBB, 32'hCC, 5'd4, 32'h4444, 16'h0044);
    step();
    in_valid = 1'b0;
    chk("b2b_read_out_valid", out_valid, 0);
    step();
    step();

    // Flush while in READ: nothing reaches VALID, no accept in the flush cycle.
    issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd8, 32'h8, 16'h0008);
    step();
    issue(5'd6, 5'd5, 1'b1, 1'b1, 5'd9, 32'h9, 16'h0009);
    flush = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 0);
    chk("flush_rd1_en", rf_rd_1_en, 0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    step();
    chk("flush_out_valid_later", out_valid, 0);

    // Reset asserted while VALID clears outputs immediately.
    out_ready = 1'b0;
    issue(5'd5, 5'd6, 1'b1, 1'b1, 5'd9, 32'hDEAD, 16'h0001);
    step();
    in_valid = 1'b0;
    step();
    chk("pre_reset_valid", out_valid, 1);
    chk("pre_reset_rd", out_rd, 9);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_op1", out_op1, 0);
    chk("mid_reset_op2", out_op2, 0);
    chk("mid_reset_rd", out_rd, 0);
    chk("mid_reset_imm", out_imm, 0);
    chk("mid_reset_ctrl", out_ctrl, 0);
    step();
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    chk("post_reset_valid", out_valid, 0);
    chk("post_reset_in_ready", in_ready, 1);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute stage that reads source operands from the dual-port BRAM register file and hands them to the ALU. It accepts a decoded instruction over a valid/ready handshake, issues the register-file reads, and waits the one-cycle BRAM latency. It then presents registered operands to the execute stage, with writeback bypass covering the BRAM read-during-write gap.

## Interface
Parameters:
- CTRL_W, 16, width of opaque decoded-control bundle passed through to execute

Ports:
- clk  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous discard of in-flight instruction (branch/jump redirect)
- in_valid  in  1  decoded instruction available
- in_ready  out  1  stage accepts instruction this cycle
- in_rs1, in_rs2  in  5 each  source register indices
- in_uses_rs1, in_uses_rs2  in  1 each  operand actually needed
- in_rd  in  5  destination index, passed through
- in_imm  in  32  immediate, passed through
- in_ctrl  in  CTRL_W  control bundle, passed through
- rf_rd_1_en, rf_rd_2_en  out  1 each  register-file read enables
- rf_read_reg_1, rf_read_reg_2  out  5 each  register-file read addresses
- rf_data_out_1, rf_data_out_2  in  32 each  register-file read data, valid the cycle after enable
- wb_en, wb_reg, wb_data  in  1/5/32  writeback port, same signals that drive the register-file write port
- out_valid  out  1  operands valid
- out_ready  in  1  execute consumes this cycle
- out_op1, out_op2  out  32 each  resolved operands
- out_rd, out_imm, out_ctrl  out  5/32/CTRL_W  registered pass-through

## Operation
- States: IDLE, READ, VALID.
- Accept = in_valid && in_ready. in_ready = !flush && (state==IDLE || (state==VALID && out_ready)).
- On accept:
  - rf_rd_N_en = in_uses_rsN && in_rsN!=0, combinationally in the accept cycle.
  - rf_read_reg_N = in_rsN.
  - rd/imm/ctrl/uses/rs captured.
  - Next state is READ.
- No read enables outside accept cycles, so BRAM output stays stable.
- READ: at the next edge, operands are resolved into out_opN. Unconditional transition to VALID.
- VALID: out_valid=1. On out_ready, go to IDLE, or to READ if a new accept occurs the same cycle.
- Operand resolution per operand, priority high to low:
  1. !uses_rsN or rsN==0 gives 0.
  2. wb_en && wb_reg==rsN at the resolving edge gives wb_data.
  3. wb write to rsN captured at the accept edge gives the captured wb_data. The BRAM returns the old value on same-edge write.
  4. Otherwise rf_data_out_N.
- Hold update: in VALID with !out_ready, a wb_en write (wb_reg!=0) matching a used rsN overwrites out_opN at that edge.
- flush: state goes to IDLE and out_valid falls at the next edge. Any READ/VALID content is dropped. No accept in a flush cycle.
- wb_reg==0 never bypasses.

## Timing
- Reset values:
  - state IDLE
  - out_valid 0; out_op1/op2/imm 0; out_rd 0; out_ctrl 0
  - captured bypass flags 0
  - in_ready goes 1 once reset deasserts
- Reset mid-operation: in-flight instruction lost, with no partial outputs.
- Latency: accept at edge E gives out_valid high from E+1 to E+2.
- Throughput: at most one instruction per 2 cycles (READ always precedes VALID).
- Outputs are fully registered. in_ready and rf_* are combinational from state, flush, in_*, out_ready.
- out_* stable while out_valid && !out_ready, except the hold-update bypass.

## Structure
- cpu_pkg holds XLEN=32, REG_IDX_W=5, REG_ZERO=5'd0, and the state enum (of_state_t: IDLE, READ, VALID).
- Sub-module operand_bypass (combinational, instantiated twice) implements the per-operand priority select. Its inputs are uses, rs, rf_data, wb_en/reg/data, and captured flag/data.

## Test plan
- Basic read: preload x5=0x11, x6=0x22; issue rs1=5, rs2=6 with out_ready=1. Expect rf_rd_1_en=rf_rd_2_en=1 in the accept cycle, then out_valid two edges later with op1=0x11, op2=0x22.
- Accept-edge bypass: wb writes x5=0xAA on the accept edge (regfile returns old 0x11). Expect op1=0xAA.
- Resolving-edge bypass: wb writes x6=0xBB on the READ-to-VALID edge. Expect op2=0xBB. When a write at both edges targets the same register, expect the later value.
- x0 / unused: rs1=0 with wb writing x0=0xFF, and uses_rs2=0. Expect op1=0, op2=0, and rf_rd_1_en=rf_rd_2_en=0.
- Backpressure: out_ready=0 for 3 cycles. Expect out_* stable and in_ready=0. A wb write to rs1 during the hold updates op1. On out_ready=1 with in_valid=1, expect consume and accept in the same cycle.
- Flush/reset:
  - flush in READ gives out_valid=0 next cycle, with no accept that cycle.
  - reset asserted in VALID gives out_valid=0 immediately and all outputs zero.
